// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush, data-memory wait.
// Stage sel/pc_en outputs are combinational; state and counters update on clk_i.
module hazard_ctrl #(
    parameter int unsigned LU_BUBBLES  = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       ifid_rs1_adi,
    input  logic [4:0]       ifid_rs2_adi,
    input  logic [4:0]       idex_rd_adi,
    input  logic             idex_rd_wreni,
    input  logic             idex_mem_rdi,
    input  logic             br_seli,
    input  logic             exmem_acci,
    input  logic             mem_rdyi,
    output logic             pc_en_o,
    output logic [1:0]       ifid_sel_o,
    output logic [1:0]       idex_sel_o,
    output logic [1:0]       exmem_sel_o,
    output logic [1:0]       memwb_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    typedef enum logic {RUN, LU_STALL} state_t;

    localparam logic [1:0]       SEL_LOAD = 2'b00;
    localparam logic [1:0]       SEL_HOLD = 2'b01;
    localparam logic [1:0]       SEL_CLR  = 2'b11;
    localparam logic [2:0]       LU_INIT  = 3'(LU_BUBBLES - 1);
    localparam logic [7:0]       TMO      = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic             lu_hit;
    logic             mem_wait;
    logic             pc_en;
    logic [1:0]       ifid_sel, idex_sel, exmem_sel, memwb_sel;

    assign lu_hit = idex_mem_rdi & idex_rd_wreni & (idex_rd_adi != 5'd0) &
                    ((idex_rd_adi == ifid_rs1_adi) | (idex_rd_adi == ifid_rs2_adi));
    assign mem_wait = exmem_acci & ~mem_rdyi;

    always_comb begin
        state_d   = state_q;
        bub_d     = bub_q;
        wait_d    = 8'd0;
        err_d     = err_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        pc_en     = 1'b1;
        ifid_sel  = SEL_LOAD;
        idex_sel  = SEL_LOAD;
        exmem_sel = SEL_LOAD;
        memwb_sel = SEL_LOAD;

        if (mem_wait) begin
            pc_en     = 1'b0;
            ifid_sel  = SEL_HOLD;
            idex_sel  = SEL_HOLD;
            exmem_sel = SEL_HOLD;
            memwb_sel = SEL_CLR;
            // Wait counter parks at its maximum so a long wait cannot wrap.
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
            if (wait_d >= TMO) begin
                err_d = 1'b1;
            end
        end else if (br_seli) begin
            ifid_sel = SEL_CLR;
            idex_sel = SEL_CLR;
            flush_d  = (flush_q == '1) ? flush_q : flush_q + CNT_ONE;
            state_d  = RUN;
            bub_d    = 3'd0;
        end else if (state_q == LU_STALL || lu_hit) begin
            pc_en    = 1'b0;
            ifid_sel = SEL_HOLD;
            idex_sel = SEL_CLR;
            if (state_q == LU_STALL) begin
                if (bub_q == 3'd1) begin
                    state_d = RUN;
                    bub_d   = 3'd0;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end else if (LU_BUBBLES > 1) begin
                state_d = LU_STALL;
                bub_d   = LU_INIT;
            end
        end

        if (!pc_en) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            bub_q   <= 3'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Every stage register is cleared and fetch held while reset is asserted.
    assign pc_en_o     = rst_ni & pc_en;
    assign ifid_sel_o  = rst_ni ? ifid_sel  : SEL_CLR;
    assign idex_sel_o  = rst_ni ? idex_sel  : SEL_CLR;
    assign exmem_sel_o = rst_ni ? exmem_sel : SEL_CLR;
    assign memwb_sel_o = rst_ni ? memwb_sel : SEL_CLR;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LU_BUBBLES=2, MEM_TIMEOUT=4, CNT_W=8).
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] ifid_rs1_adi, ifid_rs2_adi, idex_rd_adi;
    logic       idex_rd_wreni, idex_mem_rdi, br_seli, exmem_acci, mem_rdyi;
    logic       pc_en_o, err_o;
    logic [1:0] ifid_sel_o, idex_sel_o, exmem_sel_o, memwb_sel_o;
    logic [7:0] stall_cnt_o, flush_cnt_o;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    localparam logic [8:0] O_NORMAL = 9'b1_00_00_00_00;
    localparam logic [8:0] O_STALL  = 9'b0_01_11_00_00;
    localparam logic [8:0] O_FLUSH  = 9'b1_11_11_00_00;
    localparam logic [8:0] O_WAIT   = 9'b0_01_01_01_11;
    localparam logic [8:0] O_RESET  = 9'b0_11_11_11_11;

    hazard_ctrl #(.LU_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ifid_rs1_adi(ifid_rs1_adi), .ifid_rs2_adi(ifid_rs2_adi),
        .idex_rd_adi(idex_rd_adi), .idex_rd_wreni(idex_rd_wreni),
        .idex_mem_rdi(idex_mem_rdi), .br_seli(br_seli),
        .exmem_acci(exmem_acci), .mem_rdyi(mem_rdyi),
        .pc_en_o(pc_en_o), .ifid_sel_o(ifid_sel_o), .idex_sel_o(idex_sel_o),
        .exmem_sel_o(exmem_sel_o), .memwb_sel_o(memwb_sel_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    assign outs = {pc_en_o, ifid_sel_o, idex_sel_o, exmem_sel_o, memwb_sel_o};

    task automatic idle();
        ifid_rs1_adi = 5'd0; ifid_rs2_adi = 5'd0; idex_rd_adi = 5'd0;
        idex_rd_wreni = 1'b0; idex_mem_rdi = 1'b0; br_seli = 1'b0;
        exmem_acci = 1'b0; mem_rdyi = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        idex_rd_adi = rd; idex_rd_wreni = 1'b1; idex_mem_rdi = 1'b1;
        ifid_rs1_adi = rs1; ifid_rs2_adi = rs2;
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        exmem_acci = 1'b1; mem_rdyi = 1'b0;
        step(); step(); step();
        checks++;
        if (outs !== O_RESET) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, O_RESET); end
        checks++;
        if (stall_cnt_o !== 8'd0 || flush_cnt_o !== 8'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got stall %0d flush %0d err %b exp 0 0 0", stall_cnt_o, flush_cnt_o, err_o);
        end
        idle();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL reset_release got %b exp %b", outs, O_NORMAL); end
        step();
        checks++;
        if (stall_cnt_o !== 8'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_after got stall %0d err %b exp 0 0", stall_cnt_o, err_o);
        end
    endtask

    task automatic test_load_use();
        load_use(5'd5, 5'd1, 5'd5);
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lu_bubble1 got %b exp %b", outs, O_STALL); end
        step();
        // EX now holds the inserted bubble; the stall must continue from state alone.
        idle();
        ifid_rs2_adi = 5'd5;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lu_bubble2 got %b exp %b", outs, O_STALL); end
        step();
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL lu_resume got %b exp %b", outs, O_NORMAL); end
        exp_stall = 2;
        checks++;
        if (stall_cnt_o !== 8'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt_o, exp_stall); end
        idle();
    endtask

    task automatic test_no_hazard();
        load_use(5'd0, 5'd0, 5'd3);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL x0_no_stall got %b exp %b", outs, O_NORMAL); end
        step();
        load_use(5'd7, 5'd7, 5'd2);
        idex_mem_rdi = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL non_load got %b exp %b", outs, O_NORMAL); end
        step();
        load_use(5'd9, 5'd8, 5'd10);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL no_match got %b exp %b", outs, O_NORMAL); end
        step();
        checks++;
        if (stall_cnt_o !== 8'(exp_stall)) begin errors++; $display("FAIL no_hazard_cnt got %0d exp %0d", stall_cnt_o, exp_stall); end
        idle();
    endtask

    task automatic test_branch_in_stall();
        load_use(5'd4, 5'd4, 5'd0);
        step();
        idle();
        br_seli = 1'b1;
        #1;
        checks++;
        if (outs !== O_FLUSH) begin errors++; $display("FAIL br_flush got %b exp %b", outs, O_FLUSH); end
        step();
        idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL br_cancels_lu got %b exp %b", outs, O_NORMAL); end
        exp_stall += 1;
        exp_flush = 1;
        checks++;
        if (flush_cnt_o !== 8'(exp_flush) || stall_cnt_o !== 8'(exp_stall)) begin
            errors++; $display("FAIL br_cnt got flush %0d stall %0d exp %0d %0d", flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
        end
    endtask

    task automatic test_wait_in_stall();
        load_use(5'd6, 5'd6, 5'd6);
        step();
        idle();
        exmem_acci = 1'b1; mem_rdyi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== O_WAIT) begin errors++; $display("FAIL wait_outs[%0d] got %b exp %b", i, outs, O_WAIT); end
            step();
        end
        mem_rdyi = 1'b1;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL wait_frozen_bubble got %b exp %b", outs, O_STALL); end
        step();
        checks++;
        if (outs !== O_NORMAL) begin errors++; $display("FAIL wait_resume got %b exp %b", outs, O_NORMAL); end
        exp_stall += 5;
        checks++;
        if (stall_cnt_o !== 8'(exp_stall) || err_o !== 1'b0) begin
            errors++; $display("FAIL wait_cnt got stall %0d err %b exp %0d 0", stall_cnt_o, err_o, exp_stall);
        end
        idle();
    endtask

    task automatic test_timeout();
        idle();
        exmem_acci = 1'b1; mem_rdyi = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (err_o !== (i >= 4)) begin errors++; $display("FAIL timeout_err[%0d] got %b exp %b", i, err_o, (i >= 4)); end
        end
        mem_rdyi = 1'b1;
        step(); step();
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
        exp_stall += 6;
        checks++;
        if (stall_cnt_o !== 8'(exp_stall)) begin errors++; $display("FAIL timeout_stall_cnt got %0d exp %0d", stall_cnt_o, exp_stall); end
        idle();
    endtask

    task automatic test_saturation();
        exmem_acci = 1'b1; mem_rdyi = 1'b0;
        for (int i = 0; i < 300; i++) step();
        checks++;
        if (stall_cnt_o !== 8'hFF) begin errors++; $display("FAIL stall_sat got %0d exp 255", stall_cnt_o); end
        idle();
        br_seli = 1'b1;
        for (int i = 0; i < 300; i++) step();
        checks++;
        if (flush_cnt_o !== 8'hFF || stall_cnt_o !== 8'hFF) begin
            errors++; $display("FAIL flush_sat got flush %0d stall %0d exp 255 255", flush_cnt_o, stall_cnt_o);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_in_stall();
        test_wait_in_stall();
        test_timeout();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
